kws_decision_smoother: RTL and testbench
========================================

Name: kws_decision_smoother

Overview:
- Post-processing stage directly downstream of the CNN keyword-spotting accelerator; consumes its per-frame one-hot classification (kws_result/kws_valid).
- Suppresses single-frame false triggers with a sliding-window vote over the last WINDOW frames, a programmable threshold and a refractory hold-off.
- Emits one single-cycle detection event per spoken keyword to the host/interrupt logic.

Parameters:
- NUM_KEYWORDS, 10, width of the one-hot class vector.
- WINDOW, 8, history depth in frames (2..64).
- IDX_BITS, 4, width of keyword index; must satisfy 2^IDX_BITS > NUM_KEYWORDS.
- SILENCE_IDX, 0, class index that is counted but never reported (silence/unknown).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush of history, counts, hold-off and pipeline.
- kws_result  input  NUM_KEYWORDS  one-hot frame classification.
- kws_valid  input  1  frame strobe; may be high on consecutive cycles.
- threshold  input  8  minimum votes in window to detect; quasi-static.
- holdoff_frames  input  8  frames ignored after a detection; quasi-static.
- det_valid  output  1  one-cycle detection pulse.
- det_keyword  output  IDX_BITS  detected keyword index, held until next detection.
- det_score  output  8  vote count at detection, held until next detection.
- holdoff_active  output  1  high while hold-off counter is nonzero.
- fill_level  output  8  valid history entries (0..WINDOW).

Behaviour:
- Reset (rst_n low, async): all outputs 0; history, per-keyword counters, fill, hold-off counter, pipeline registers 0.
- Encode: exactly one bit set -> index of that bit. Zero or multiple bits set -> NONE code (NUM_KEYWORDS). NONE occupies a history slot but has no counter.
- Stage 1 (edge E0 with kws_valid=1, holdoff_cnt=0, no clear, no flush):
  - Write index into circular history at wr_ptr; wr_ptr wraps WINDOW-1 -> 0.
  - If fill==WINDOW, the evicted entry's counter decrements; otherwise fill increments.
  - New index's counter increments. If new == evicted, counts are unchanged.
  - Counters never exceed WINDOW and never underflow.
  - Register cand_idx and cand_valid.
- Stage 2 (edge E1):
  - eff_thr = max(threshold, 1).
  - Detect when all hold: cand_valid; cand_idx != NONE; cand_idx != SILENCE_IDX; count[cand_idx] >= eff_thr. The count used is the post-E0 value.
  - On detect:
    - det_valid=1 for exactly the cycle after E1.
    - Load det_keyword and det_score.
    - Load holdoff_cnt=holdoff_frames.
    - Flush history, counters, fill and wr_ptr to 0.
- Latency: kws_valid at E0 -> det_valid high after E1 (2-cycle latency).
- Simultaneous detect flush at E1 and kws_valid at E1: flush wins. The E1 frame is discarded and does not decrement hold-off.
- Hold-off:
  - While holdoff_cnt != 0, each kws_valid frame is discarded (not recorded) and decrements holdoff_cnt by 1.
  - holdoff_frames=0 means no hold-off.
  - holdoff_active = (holdoff_cnt != 0).
- threshold > WINDOW: detection never fires.
- clear (synchronous): same effect as reset on internal state and det_valid. det_keyword/det_score are also zeroed. Takes priority over kws_valid in the same cycle.
- Reset or clear mid-pipeline: a pending stage-1 candidate is dropped; no det_valid follows.
- fill_level = fill count.

Test Plan:
- WINDOW=8, threshold=3, holdoff=0. Frames: kw5, kw5, kw2, kw5 on consecutive kws_valid cycles -> single det_valid 2 cycles after the 4th frame; det_keyword=5, det_score=3; fill_level then reads 0.
- threshold=8. 12 frames alternating kw3/kw4 -> no det_valid. Counts saturate at 4/4 after wrap. fill_level=8.
- threshold=2, holdoff=4. kw7, kw7 -> detect. Next 4 kw7 frames ignored with holdoff_active=1; then kw7, kw7 -> second detect.
- SILENCE_IDX=0. 8 frames of kw0 with threshold=1 -> no det_valid. Multi-hot 10'b0000000011 frames -> counted as NONE, no detect, fill increments.
- Detect at E1 while another kws_valid arrives at E1 -> that frame is dropped. fill_level=0 after E1.
- threshold=0 -> first valid kw1 frame detects with det_score=1.
- clear asserted one cycle after a threshold-crossing frame -> no det_valid, all counts 0.
- rst_n pulsed mid-window -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/kws_decision_smoother.sv
// kws_decision_smoother
// Temporal smoothing of per-frame keyword classifications. Keeps a circular
// history of the last WINDOW frame indices with a vote counter per keyword.
// A keyword is reported once its vote count reaches the threshold. After each
// report the history is flushed and a hold-off period ignores frames.
module kws_decision_smoother #(
    parameter int NUM_KEYWORDS = 10,
    parameter int WINDOW       = 8,
    parameter int IDX_BITS     = 4,
    parameter int SILENCE_IDX  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [NUM_KEYWORDS-1:0] kws_result,
    input  logic                    kws_valid,
    input  logic [7:0]              threshold,
    input  logic [7:0]              holdoff_frames,
    output logic                    det_valid,
    output logic [IDX_BITS-1:0]     det_keyword,
    output logic [7:0]              det_score,
    output logic                    holdoff_active,
    output logic [7:0]              fill_level
);

    localparam int                  PTR_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_BITS-1:0] NONE_IDX = IDX_BITS'(NUM_KEYWORDS);
    localparam logic [IDX_BITS-1:0] SIL_IDX  = IDX_BITS'(SILENCE_IDX);
    localparam logic [7:0]          WIN_MAX  = 8'(WINDOW);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(WINDOW - 1);

    // Index of the single set bit; zero or several set bits map to NONE_IDX.
    function automatic logic [IDX_BITS-1:0] encode_onehot(input logic [NUM_KEYWORDS-1:0] vec);
        logic [IDX_BITS-1:0] idx;
        int unsigned         ones;
        idx  = NONE_IDX;
        ones = 32'd0;
        for (int k = 0; k < NUM_KEYWORDS; k++) begin
            if (vec[k]) begin
                ones = ones + 32'd1;
                idx  = IDX_BITS'(k);
            end
        end
        if (ones != 32'd1) begin
            idx = NONE_IDX;
        end
        return idx;
    endfunction

    // History and vote state
    logic [IDX_BITS-1:0] hist_r [WINDOW];
    logic [7:0]          cnt_r [NUM_KEYWORDS];
    logic [7:0]          cnt_next_s [NUM_KEYWORDS];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [7:0]          fill_r;
    logic [7:0]          holdoff_cnt_r;
    logic [7:0]          holdoff_next_s;

    // Stage-1 candidate
    logic [IDX_BITS-1:0] cand_idx_r;
    logic                cand_valid_r;

    // Registered outputs
    logic                det_valid_r;
    logic [IDX_BITS-1:0] det_keyword_r;
    logic [7:0]          det_score_r;
    logic                holdoff_active_r;

    // Combinational decode
    logic [IDX_BITS-1:0] new_idx_s;
    logic [IDX_BITS-1:0] evict_idx_s;
    logic                full_s;
    logic [7:0]          cand_cnt_s;
    logic [7:0]          eff_thr_s;
    logic                detect_s;
    logic                accept_s;
    logic                skip_s;

    // Frame decode, candidate vote lookup and detection decision.
    always_comb begin
        new_idx_s   = encode_onehot(kws_result);
        evict_idx_s = hist_r[wr_ptr_r];
        full_s      = (fill_r == WIN_MAX);
        cand_cnt_s  = 8'd0;
        for (int k = 0; k < NUM_KEYWORDS; k++) begin
            cand_cnt_s = (cand_idx_r == IDX_BITS'(k)) ? cnt_r[k] : cand_cnt_s;
        end
        eff_thr_s = (threshold == 8'd0) ? 8'd1 : threshold;
        detect_s  = cand_valid_r && (cand_idx_r != NONE_IDX) && (cand_idx_r != SIL_IDX)
                    && (cand_cnt_s >= eff_thr_s);
        // A detection flush wins over a frame arriving in the same cycle.
        accept_s  = kws_valid && (holdoff_cnt_r == 8'd0) && !clear && !detect_s;
        skip_s    = kws_valid && (holdoff_cnt_r != 8'd0) && !clear && !detect_s;
    end

    // Next hold-off count: reload on detect, count down on discarded frames.
    always_comb begin
        holdoff_next_s = holdoff_cnt_r;
        if (clear) begin
            holdoff_next_s = 8'd0;
        end else if (detect_s) begin
            holdoff_next_s = holdoff_frames;
        end else if (skip_s) begin
            holdoff_next_s = holdoff_cnt_r - 8'd1;
        end else begin
            holdoff_next_s = holdoff_cnt_r;
        end
    end

    // Next vote counts: increment new class, decrement evicted class, saturating.
    always_comb begin
        for (int k = 0; k < NUM_KEYWORDS; k++) begin
            cnt_next_s[k] = cnt_r[k];
            if (accept_s && (new_idx_s == IDX_BITS'(k))
                && !(full_s && (evict_idx_s == IDX_BITS'(k)))
                && (cnt_r[k] != WIN_MAX)) begin
                cnt_next_s[k] = cnt_r[k] + 8'd1;
            end else if (accept_s && full_s && (evict_idx_s == IDX_BITS'(k))
                         && (new_idx_s != IDX_BITS'(k)) && (cnt_r[k] != 8'd0)) begin
                cnt_next_s[k] = cnt_r[k] - 8'd1;
            end else begin
                cnt_next_s[k] = cnt_r[k];
            end
        end
    end

    // History, counters, write pointer, fill and stage-1 candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WINDOW; i++) begin
                hist_r[i] <= {IDX_BITS{1'b0}};
            end
            for (int k = 0; k < NUM_KEYWORDS; k++) begin
                cnt_r[k] <= 8'd0;
            end
            wr_ptr_r     <= {PTR_W{1'b0}};
            fill_r       <= 8'd0;
            cand_idx_r   <= {IDX_BITS{1'b0}};
            cand_valid_r <= 1'b0;
        end else if (clear || detect_s) begin
            for (int i = 0; i < WINDOW; i++) begin
                hist_r[i] <= {IDX_BITS{1'b0}};
            end
            for (int k = 0; k < NUM_KEYWORDS; k++) begin
                cnt_r[k] <= 8'd0;
            end
            wr_ptr_r     <= {PTR_W{1'b0}};
            fill_r       <= 8'd0;
            cand_idx_r   <= {IDX_BITS{1'b0}};
            cand_valid_r <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_KEYWORDS; k++) begin
                cnt_r[k] <= cnt_next_s[k];
            end
            cand_valid_r <= accept_s;
            if (accept_s) begin
                hist_r[wr_ptr_r] <= new_idx_s;
                wr_ptr_r         <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
                fill_r           <= full_s ? fill_r : fill_r + 8'd1;
                cand_idx_r       <= new_idx_s;
            end
        end
    end

    // Detection outputs and hold-off state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_valid_r      <= 1'b0;
            det_keyword_r    <= {IDX_BITS{1'b0}};
            det_score_r      <= 8'd0;
            holdoff_cnt_r    <= 8'd0;
            holdoff_active_r <= 1'b0;
        end else if (clear) begin
            det_valid_r      <= 1'b0;
            det_keyword_r    <= {IDX_BITS{1'b0}};
            det_score_r      <= 8'd0;
            holdoff_cnt_r    <= 8'd0;
            holdoff_active_r <= 1'b0;
        end else begin
            det_valid_r      <= detect_s;
            holdoff_cnt_r    <= holdoff_next_s;
            holdoff_active_r <= (holdoff_next_s != 8'd0);
            if (detect_s) begin
                det_keyword_r <= cand_idx_r;
                det_score_r   <= cand_cnt_s;
            end
        end
    end

    assign det_valid      = det_valid_r;
    assign det_keyword    = det_keyword_r;
    assign det_score      = det_score_r;
    assign holdoff_active = holdoff_active_r;
    assign fill_level     = fill_r;

endmodule

// File: tb/tb_kws_decision_smoother.sv
// Directed testbench for kws_decision_smoother (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_kws_decision_smoother;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [9:0] kws_result;
    logic       kws_valid;
    logic [7:0] threshold;
    logic [7:0] holdoff_frames;
    logic       det_valid;
    logic [3:0] det_keyword;
    logic [7:0] det_score;
    logic       holdoff_active;
    logic [7:0] fill_level;

    int tests_run = 0;
    int fails     = 0;
    int det_pulses = 0;
    int base;

    kws_decision_smoother dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .kws_result     (kws_result),
        .kws_valid      (kws_valid),
        .threshold      (threshold),
        .holdoff_frames (holdoff_frames),
        .det_valid      (det_valid),
        .det_keyword    (det_keyword),
        .det_score      (det_score),
        .holdoff_active (holdoff_active),
        .fill_level     (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count detection pulses seen at rising edges.
    always @(posedge clk) begin
        if (det_valid === 1'b1) det_pulses <= det_pulses + 1;
    end

    function automatic logic [9:0] kw(input int n);
        logic [9:0] one;
        one = 10'd1;
        return one << n;
    endfunction

    task automatic drive(input logic [9:0] v, input logic vld, input logic clr);
        @(negedge clk);
        kws_result = v;
        kws_valid  = vld;
        clear      = clr;
    endtask

    task automatic frame_gap(input logic [9:0] v);
        drive(v, 1'b1, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        drive(10'd0, 1'b0, 1'b1);
        drive(10'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({det_valid, det_keyword, det_score, holdoff_active, fill_level} !== 22'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {det_valid, det_keyword, det_score, holdoff_active, fill_level});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_detect();
        threshold = 8'd3; holdoff_frames = 8'd0;
        base = det_pulses;
        drive(kw(5), 1'b1, 1'b0);
        drive(kw(5), 1'b1, 1'b0);
        drive(kw(2), 1'b1, 1'b0);
        drive(kw(5), 1'b1, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_valid !== 1'b0) begin fails++; $display("FAIL basic_early: got %b expected 0", det_valid); end
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_valid !== 1'b1) begin fails++; $display("FAIL basic_det_valid: got %b expected 1", det_valid); end
        tests_run++;
        if (det_keyword !== 4'd5) begin fails++; $display("FAIL basic_keyword: got %0d expected 5", det_keyword); end
        tests_run++;
        if (det_score !== 8'd3) begin fails++; $display("FAIL basic_score: got %0d expected 3", det_score); end
        tests_run++;
        if (fill_level !== 8'd0) begin fails++; $display("FAIL basic_fill: got %0d expected 0", fill_level); end
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse_width: got %b expected 0", det_valid); end
        tests_run++;
        if (det_keyword !== 4'd5) begin fails++; $display("FAIL basic_keyword_hold: got %0d expected 5", det_keyword); end
        tests_run++;
        if (det_pulses - base !== 1) begin fails++; $display("FAIL basic_pulse_count: got %0d expected 1", det_pulses - base); end
    endtask

    task automatic test_window_wrap();
        do_clear();
        threshold = 8'd8; holdoff_frames = 8'd0;
        base = det_pulses;
        for (int i = 0; i < 12; i++) drive((i % 2 == 0) ? kw(3) : kw(4), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_pulses - base !== 0) begin fails++; $display("FAIL wrap_no_detect: got %0d expected 0", det_pulses - base); end
        tests_run++;
        if (fill_level !== 8'd8) begin fails++; $display("FAIL wrap_fill: got %0d expected 8", fill_level); end
        // kw4 replaces an old kw3 entry: kw4 votes 4 -> 5.
        threshold = 8'd4;
        drive(kw(4), 1'b1, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_valid !== 1'b1) begin fails++; $display("FAIL wrap_det_valid: got %b expected 1", det_valid); end
        tests_run++;
        if (det_keyword !== 4'd4) begin fails++; $display("FAIL wrap_keyword: got %0d expected 4", det_keyword); end
        tests_run++;
        if (det_score !== 8'd5) begin fails++; $display("FAIL wrap_score: got %0d expected 5", det_score); end
    endtask

    task automatic test_holdoff();
        do_clear();
        threshold = 8'd2; holdoff_frames = 8'd4;
        base = det_pulses;
        frame_gap(kw(7));
        frame_gap(kw(7));
        tests_run++;
        if (det_pulses - base !== 1) begin fails++; $display("FAIL holdoff_first_detect: got %0d expected 1", det_pulses - base); end
        tests_run++;
        if (det_score !== 8'd2) begin fails++; $display("FAIL holdoff_score: got %0d expected 2", det_score); end
        tests_run++;
        if (holdoff_active !== 1'b1) begin fails++; $display("FAIL holdoff_active_set: got %b expected 1", holdoff_active); end
        for (int i = 0; i < 3; i++) frame_gap(kw(7));
        tests_run++;
        if (holdoff_active !== 1'b1) begin fails++; $display("FAIL holdoff_active_3: got %b expected 1", holdoff_active); end
        frame_gap(kw(7));
        tests_run++;
        if (holdoff_active !== 1'b0) begin fails++; $display("FAIL holdoff_active_end: got %b expected 0", holdoff_active); end
        tests_run++;
        if (fill_level !== 8'd0 || det_pulses - base !== 1) begin
            fails++; $display("FAIL holdoff_discard: got fill %0d pulses %0d expected 0 1", fill_level, det_pulses - base);
        end
        frame_gap(kw(7));
        frame_gap(kw(7));
        tests_run++;
        if (det_pulses - base !== 2) begin fails++; $display("FAIL holdoff_second_detect: got %0d expected 2", det_pulses - base); end
    endtask

    task automatic test_silence_none();
        do_clear();
        threshold = 8'd1; holdoff_frames = 8'd0;
        base = det_pulses;
        for (int i = 0; i < 8; i++) drive(kw(0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_pulses - base !== 0) begin fails++; $display("FAIL silence_no_detect: got %0d expected 0", det_pulses - base); end
        tests_run++;
        if (fill_level !== 8'd8) begin fails++; $display("FAIL silence_fill: got %0d expected 8", fill_level); end
        do_clear();
        for (int i = 0; i < 3; i++) drive(10'b0000000011, 1'b1, 1'b0);
        drive(10'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_pulses - base !== 0) begin fails++; $display("FAIL none_no_detect: got %0d expected 0", det_pulses - base); end
        tests_run++;
        if (fill_level !== 8'd4) begin fails++; $display("FAIL none_fill: got %0d expected 4", fill_level); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        threshold = 8'd1; holdoff_frames = 8'd1;
        base = det_pulses;
        drive(kw(6), 1'b1, 1'b0);
        drive(kw(6), 1'b1, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_valid !== 1'b1 || det_keyword !== 4'd6 || det_score !== 8'd1) begin
            fails++; $display("FAIL b2b_detect: got v%b k%0d s%0d expected v1 k6 s1", det_valid, det_keyword, det_score);
        end
        tests_run++;
        if (fill_level !== 8'd0) begin fails++; $display("FAIL b2b_fill: got %0d expected 0", fill_level); end
        tests_run++;
        if (holdoff_active !== 1'b1) begin fails++; $display("FAIL b2b_holdoff_kept: got %b expected 1", holdoff_active); end
        drive(10'd0, 1'b0, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_pulses - base !== 1 || fill_level !== 8'd0) begin
            fails++; $display("FAIL b2b_dropped: got pulses %0d fill %0d expected 1 0", det_pulses - base, fill_level);
        end
    endtask

    task automatic test_zero_threshold();
        do_clear();
        threshold = 8'd0; holdoff_frames = 8'd0;
        drive(kw(1), 1'b1, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_valid !== 1'b1 || det_keyword !== 4'd1 || det_score !== 8'd1) begin
            fails++; $display("FAIL thr0_detect: got v%b k%0d s%0d expected v1 k1 s1", det_valid, det_keyword, det_score);
        end
    endtask

    task automatic test_clear_mid();
        do_clear();
        threshold = 8'd2; holdoff_frames = 8'd0;
        base = det_pulses;
        frame_gap(kw(8));
        drive(kw(8), 1'b1, 1'b0);
        drive(10'd0, 1'b0, 1'b1);
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (det_valid !== 1'b0 || fill_level !== 8'd0) begin
            fails++; $display("FAIL clear_drop: got v%b fill %0d expected v0 fill 0", det_valid, fill_level);
        end
        tests_run++;
        if (det_keyword !== 4'd0 || det_score !== 8'd0) begin
            fails++; $display("FAIL clear_outputs: got k%0d s%0d expected k0 s0", det_keyword, det_score);
        end
        frame_gap(kw(8));
        tests_run++;
        if (det_pulses - base !== 0 || fill_level !== 8'd1) begin
            fails++; $display("FAIL clear_counts: got pulses %0d fill %0d expected 0 1", det_pulses - base, fill_level);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        threshold = 8'd1; holdoff_frames = 8'd0;
        frame_gap(kw(9));
        threshold = 8'd8;
        for (int i = 0; i < 3; i++) drive(kw(3), 1'b1, 1'b0);
        drive(10'd0, 1'b0, 1'b0);
        tests_run++;
        if (fill_level !== 8'd3 || det_keyword !== 4'd9) begin
            fails++; $display("FAIL prereset_state: got fill %0d k%0d expected 3 9", fill_level, det_keyword);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({det_valid, det_keyword, det_score, holdoff_active, fill_level} !== 22'd0) begin
            fails++; $display("FAIL async_reset: got %h expected 0",
                              {det_valid, det_keyword, det_score, holdoff_active, fill_level});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; kws_result = 10'd0; kws_valid = 1'b0;
        threshold = 8'd3; holdoff_frames = 8'd0;
        test_reset();
        test_basic_detect();
        test_window_wrap();
        test_holdoff();
        test_silence_none();
        test_back_to_back();
        test_zero_threshold();
        test_clear_mid();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
